gate_fold_packer: RTL and testbench
===================================

Name: gate_fold_packer

Overview:
- TX-side stage that sits between the NoC gate outputs (flits, valids, credits) and the LVDS serializer.
- Captures one emulation-cycle snapshot of a gate and folds it into GATE_FOLDS words, each LVDS_CHANNELS*LVDS_SERIALIZATION bits wide.
- Emits those words under a ready/valid handshake. Also drives the link training word while sync is requested.
- Reports frame completion to the emulation state machine.

Parameters:
- FLIT_WIDTH, 8, bits per flit
- GATE_WIDTH, 8, flits/valids/credits per gate
- GATE_FOLDS, 3, words per frame
- LVDS_SERIALIZATION, 4, bits per channel per word
- LVDS_CHANNELS, 7, LVDS data channels
- SYNC_PATTERN, 1, per-channel training nibble (low LVDS_SERIALIZATION bits used)

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  asynchronous active-high reset
- i_tx_start  in  1  one-cycle pulse: capture snapshot and send a frame
- o_tx_done  out  1  high when idle and no frame is outstanding
- i_sync_generate  in  1  level: emit training words while high
- i_dt  in  [GATE_WIDTH] x FLIT_WIDTH  flits
- i_vl  in  GATE_WIDTH  valids
- i_cr  in  GATE_WIDTH  credits
- o_word  out  W  folded word to serializer
- o_word_valid  out  1  o_word is meaningful
- o_word_first  out  1  o_word is fold 0 of a frame
- i_word_ready  in  1  serializer accepts o_word this cycle

Behaviour:
- Derived widths: W = LVDS_CHANNELS*LVDS_SERIALIZATION (28). P = GATE_WIDTH*(FLIT_WIDTH+2) (80).
- Elaboration error unless GATE_FOLDS*W >= P.
- Payload vector layout:
  - bit [i*FLIT_WIDTH +: FLIT_WIDTH] = i_dt[i]
  - then i_vl at [GATE_WIDTH*FLIT_WIDTH +: GATE_WIDTH]
  - then i_cr above that
  - zero-padded to GATE_FOLDS*W
  - fold k = bits [k*W +: W].
- SYNC_WORD = SYNC_PATTERN[LVDS_SERIALIZATION-1:0] replicated LVDS_CHANNELS times (0x1111111 at defaults).
- Reset values: state IDLE, o_tx_done=1, o_word=0, o_word_valid=0, o_word_first=0, fold counter 0, snapshot register 0.
- FSM states: IDLE, SYNC, SEND.
- IDLE:
  - Outputs: o_word=0, o_word_valid=0.
  - If i_sync_generate=1, go to SYNC. Sync has priority over a simultaneous i_tx_start, and that start is dropped.
  - Else if i_tx_start=1, register the snapshot, set fold=0, set o_tx_done=0, go to SEND. o_word_valid rises the next cycle.
- SYNC:
  - Outputs: o_word=SYNC_WORD, o_word_valid=1, o_word_first=0. i_word_ready is ignored.
  - Return to IDLE the cycle after i_sync_generate falls.
  - i_tx_start is ignored in SYNC.
- SEND:
  - Outputs: o_word = fold(fold counter) of the snapshot, o_word_valid=1, o_word_first = (fold==0).
  - o_word is held stable while i_word_ready=0.
  - On i_word_ready=1, fold increments.
  - On acceptance of fold GATE_FOLDS-1, go to IDLE; o_tx_done=1 and o_word_valid=0 on the next cycle.
  - i_tx_start during SEND is ignored.
  - i_sync_generate during SEND is deferred: the frame completes, then IDLE sees sync.
- Back-to-back frames: i_tx_start may arrive on the first cycle o_tx_done=1. That gives a one-cycle bubble between frames, with no loss.
- Snapshot is captured only on the start cycle; i_dt/i_vl/i_cr may change freely afterwards.
- Fold counter width is clog2(GATE_FOLDS), minimum 1. The counter never exceeds GATE_FOLDS-1.
- Reset asserted mid-frame: all state returns to reset values asynchronously. The partial frame is abandoned; there is no resume.

Decomposition:
- Package gate_link_pkg holds:
  - derived-width functions (word width, payload width, fold count check)
  - the FSM state enum
  - the SYNC_WORD construction function
- This package is shared with the future RX unfolder.
- Optional sub-module gate_payload_pack: combinational flatten of i_dt/i_vl/i_cr into the padded vector. All sequential logic stays in gate_fold_packer.

Test Plan:
- Reset check: assert i_rst, release -> o_tx_done=1, o_word_valid=0, o_word=0. No activity while inputs stay idle.
- Single frame:
  - Stimulus: i_dt[i]=8'h10+i, i_vl=8'hA5, i_cr=8'h3C, one start pulse, i_word_ready=1.
  - Required words: 0x3121110 (first=1), then 0x1615141, then 0x03CA517.
  - o_tx_done rises 1 cycle after the third accept.
- Backpressure: same frame with i_word_ready=0 for 5 cycles at fold 1 -> 0x1615141 held stable with valid=1. No fold skipped or duplicated.
- Sync:
  - i_sync_generate high for 10 cycles -> o_word=0x1111111, valid=1, first=0.
  - Start pulse with sync on the same IDLE cycle -> no frame sent.
  - Sync raised mid-SEND -> frame completes first.
- Start handling:
  - Start pulse during SEND -> ignored; exactly 3 words sent.
  - Start on the first o_tx_done=1 cycle -> new frame with the new snapshot values.
- Reset mid-frame: i_rst pulsed after fold 0 accepted -> outputs at reset values immediately. A following start sends a full fresh 3-word frame from fold 0.

Source files
------------

// File: rtl/gate_link_pkg.sv
// rtl/gate_link_pkg.sv - shared widths, FSM states and training word for the gate LVDS link
package gate_link_pkg;

  localparam int MAX_WORD_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEND
  } link_state_e;

  function automatic int word_width(int channels, int serialization);
    return channels * serialization;
  endfunction

  function automatic int payload_width(int gate_width, int flit_width);
    return gate_width * (flit_width + 2);
  endfunction

  function automatic bit folds_fit(int folds, int word_w, int payload_w);
    return (folds * word_w) >= payload_w;
  endfunction

  // Per-channel training nibble repeated across every channel; caller truncates to its word width.
  function automatic logic [MAX_WORD_W-1:0] sync_word(int pattern, int serialization, int channels);
    logic [MAX_WORD_W-1:0] w;
    w = '0;
    for (int c = 0; c < channels; c++) begin
      w = (w << serialization) | MAX_WORD_W'(pattern & ((1 << serialization) - 1));
    end
    return w;
  endfunction

endpackage

// File: rtl/gate_payload_pack.sv
// rtl/gate_payload_pack.sv - flattens gate flits, valids and credits into the zero-padded frame vector
module gate_payload_pack #(
  parameter int FLIT_WIDTH   = 8,
  parameter int GATE_WIDTH   = 8,
  parameter int PADDED_WIDTH = 84
) (
  input  logic [GATE_WIDTH-1:0][FLIT_WIDTH-1:0] i_dt,
  input  logic [GATE_WIDTH-1:0]                 i_vl,
  input  logic [GATE_WIDTH-1:0]                 i_cr,
  output logic [PADDED_WIDTH-1:0]               payload
);

  localparam int P = GATE_WIDTH * (FLIT_WIDTH + 2);

  // Packed flit array flattens with flit 0 in the lowest bits, valids and credits above it.
  always_comb begin
    payload        = '0;
    payload[P-1:0] = {i_cr, i_vl, i_dt};
  end

endmodule

// File: rtl/gate_fold_packer.sv
// rtl/gate_fold_packer.sv - snapshots a gate and streams it as folded LVDS words, or emits training words
module gate_fold_packer
  import gate_link_pkg::*;
#(
  parameter int FLIT_WIDTH         = 8,
  parameter int GATE_WIDTH         = 8,
  parameter int GATE_FOLDS         = 3,
  parameter int LVDS_SERIALIZATION = 4,
  parameter int LVDS_CHANNELS      = 7,
  parameter int SYNC_PATTERN       = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_tx_start,
  output logic                                  o_tx_done,
  input  logic                                  i_sync_generate,
  input  logic [GATE_WIDTH-1:0][FLIT_WIDTH-1:0] i_dt,
  input  logic [GATE_WIDTH-1:0]                 i_vl,
  input  logic [GATE_WIDTH-1:0]                 i_cr,
  output logic [LVDS_CHANNELS*LVDS_SERIALIZATION-1:0] o_word,
  output logic                                  o_word_valid,
  output logic                                  o_word_first,
  input  logic                                  i_word_ready
);

  localparam int W  = word_width(LVDS_CHANNELS, LVDS_SERIALIZATION);
  localparam int P  = payload_width(GATE_WIDTH, FLIT_WIDTH);
  localparam int FW = (GATE_FOLDS > 1) ? $clog2(GATE_FOLDS) : 1;
  localparam logic [FW-1:0] LAST_FOLD = FW'(GATE_FOLDS - 1);
  localparam logic [W-1:0]  SYNC_WORD = W'(sync_word(SYNC_PATTERN, LVDS_SERIALIZATION, LVDS_CHANNELS));

  if (!folds_fit(GATE_FOLDS, W, P)) begin : g_fold_check
    $error("gate_fold_packer: GATE_FOLDS*W is smaller than the gate payload");
  end

  link_state_e                  state, state_next;
  logic [FW-1:0]                fold, fold_next;
  logic                         tx_done_next;
  logic                         capture;
  logic [GATE_FOLDS*W-1:0]      payload;
  logic [GATE_FOLDS-1:0][W-1:0] snap;

  gate_payload_pack #(
    .FLIT_WIDTH   (FLIT_WIDTH),
    .GATE_WIDTH   (GATE_WIDTH),
    .PADDED_WIDTH (GATE_FOLDS * W)
  ) u_pack (
    .i_dt    (i_dt),
    .i_vl    (i_vl),
    .i_cr    (i_cr),
    .payload (payload)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      fold      <= '0;
      o_tx_done <= 1'b1;
      snap      <= '0;
    end else begin
      state     <= state_next;
      fold      <= fold_next;
      o_tx_done <= tx_done_next;
      if (capture) begin
        snap <= payload;
      end
    end
  end

  always_comb begin
    state_next   = state;
    fold_next    = fold;
    tx_done_next = o_tx_done;
    capture      = 1'b0;
    o_word       = '0;
    o_word_valid = 1'b0;
    o_word_first = 1'b0;
    case (state)
      ST_IDLE: begin
        // Training takes precedence; a start arriving with it is deliberately lost.
        if (i_sync_generate) begin
          state_next = ST_SYNC;
        end else if (i_tx_start) begin
          capture      = 1'b1;
          fold_next    = '0;
          tx_done_next = 1'b0;
          state_next   = ST_SEND;
        end
      end
      ST_SYNC: begin
        o_word       = SYNC_WORD;
        o_word_valid = 1'b1;
        if (!i_sync_generate) begin
          state_next = ST_IDLE;
        end
      end
      ST_SEND: begin
        o_word       = snap[fold];
        o_word_valid = 1'b1;
        o_word_first = (fold == '0);
        if (i_word_ready) begin
          if (fold == LAST_FOLD) begin
            fold_next    = '0;
            tx_done_next = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            fold_next = fold + FW'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_fold_packer.sv
// tb/tb_gate_fold_packer.sv - scoreboard bench for gate_fold_packer
module tb_gate_fold_packer;

  localparam logic [27:0] SYNC = 28'h1111111;
  localparam logic [27:0] A0 = 28'h3121110, A1 = 28'h1615141, A2 = 28'h03CA517;
  localparam logic [27:0] B0 = 28'h3222120, B1 = 28'h2625242, B2 = 28'h0C35A27;

  logic clk = 1'b0;
  logic rst, start, done, sync, valid, first, ready;
  logic [7:0][7:0] dt;
  logic [7:0] vl, cr;
  logic [27:0] word;

  typedef struct packed {
    logic [27:0] word;
    logic        first;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int n_checks = 0;
  int n_pass = 0;
  int n;

  gate_fold_packer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_tx_start      (start),
    .o_tx_done       (done),
    .i_sync_generate (sync),
    .i_dt            (dt),
    .i_vl            (vl),
    .i_cr            (cr),
    .o_word          (word),
    .o_word_valid    (valid),
    .o_word_first    (first),
    .i_word_ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_payload(logic [7:0] base, logic [7:0] v, logic [7:0] c);
    for (int i = 0; i < 8; i++) dt[i] = base + 8'(i);
    vl = v;
    cr = c;
  endtask

  task automatic push_frame(logic [27:0] f0, logic [27:0] f1, logic [27:0] f2);
    sb.push_back('{f0, 1'b1});
    sb.push_back('{f1, 1'b0});
    sb.push_back('{f2, 1'b0});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cycles++;
      if (done) return;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  // Every accepted word is either the next scoreboard entry or, with nothing queued, a training word.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (sb.size() > 0) begin
        e_mon = sb.pop_front();
        check("frame_word", 32'(word), 32'(e_mon.word));
        check("frame_first", 32'(first), 32'(e_mon.first));
      end else begin
        check("sync_word", 32'(word), 32'(SYNC));
        check("sync_first", 32'(first), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sync = 1'b0; ready = 1'b1;
    set_payload(8'h10, 8'hA5, 8'h3C);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", 32'(done), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_word", 32'(word), 32'd0);
    check("rst_first", 32'(first), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_done", 32'(done), 32'd1);

    // single frame
    @(posedge clk); #1;
    push_frame(A0, A1, A2);
    pulse_start();
    wait_done(n);
    check("frame_latency", 32'(n), 32'd4);

    // backpressure on fold 1
    @(posedge clk); #1;
    push_frame(A0, A1, A2);
    pulse_start();
    @(posedge clk); #1 ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_word", 32'(word), 32'(A1));
      check("bp_valid", 32'(valid), 32'd1);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    wait_done(n);
    check("bp_latency", 32'(n), 32'd3);

    // training words alone
    @(posedge clk); #1 sync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("sync_valid", 32'(valid), 32'd1);
    check("sync_out", 32'(word), 32'(SYNC));
    repeat (9) @(posedge clk);
    #1 sync = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("sync_exit_valid", 32'(valid), 32'd0);
    check("sync_exit_done", 32'(done), 32'd1);

    // start coinciding with sync is dropped
    @(posedge clk); #1 sync = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("sync_start_done", 32'(done), 32'd1);
    repeat (3) @(posedge clk);
    #1 sync = 1'b0;
    repeat (5) @(negedge clk);
    check("dropped_start_valid", 32'(valid), 32'd0);
    check("dropped_start_done", 32'(done), 32'd1);

    // sync raised mid-frame is deferred
    @(posedge clk); #1;
    push_frame(A0, A1, A2);
    pulse_start();
    @(posedge clk); #1 sync = 1'b1;
    wait_done(n);
    check("sync_defer_latency", 32'(n), 32'd3);
    @(posedge clk);
    @(negedge clk);
    check("defer_sync_word", 32'(word), 32'(SYNC));
    @(posedge clk); #1 sync = 1'b0;
    repeat (2) @(negedge clk);

    // start during SEND is ignored
    @(posedge clk); #1;
    push_frame(A0, A1, A2);
    pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(n);
    check("start_ignored_latency", 32'(n), 32'd2);
    repeat (4) @(negedge clk);
    check("start_ignored_valid", 32'(valid), 32'd0);

    // back-to-back frames, payload changed after capture
    @(posedge clk); #1;
    set_payload(8'h10, 8'hA5, 8'h3C);
    push_frame(A0, A1, A2);
    push_frame(B0, B1, B2);
    pulse_start();
    set_payload(8'h20, 8'h5A, 8'hC3);
    wait_done(n);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    set_payload(8'h77, 8'h00, 8'hFF);
    wait_done(n);
    check("b2b_latency", 32'(n), 32'd4);

    // reset after fold 0 accepted
    @(posedge clk); #1;
    set_payload(8'h10, 8'hA5, 8'h3C);
    sb.push_back('{A0, 1'b1});
    pulse_start();
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_word", 32'(word), 32'd0);
    check("midrst_first", 32'(first), 32'd0);
    check("midrst_done", 32'(done), 32'd1);
    @(negedge clk); rst = 1'b0;
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    set_payload(8'h20, 8'h5A, 8'hC3);
    push_frame(B0, B1, B2);
    pulse_start();
    wait_done(n);
    check("post_rst_latency", 32'(n), 32'd4);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
